// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer slice.
//   - Default widths for the instruction address, instruction word and
//     retired-instruction counter.
//   - Controller state encoding. WAIT_STEP is present only when
//     SINGLE_STEP_EN is defined.
package fetch_sequencer_pkg;

  localparam int ADDR_W_DEF  = 9;   // PC / C_bus jump target width
  localparam int INSTR_W_DEF = 16;  // instruction word width
  localparam int CNT_W_DEF   = 16;  // retired-instruction counter width

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXEC      = 3'd3,
`ifdef SINGLE_STEP_EN
    ST_HALT      = 3'd4,
    ST_WAIT_STEP = 3'd5
`else
    ST_HALT      = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/fetch_sequencer_retire_counter.sv
// Retired-instruction counter.
//   Counts inc pulses and wraps from all-ones back to zero.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (count -> 0)
//   inc    in   add one this cycle
//   count  out  CNT_W-bit running count
module fetch_sequencer_retire_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  // Plain modular addition gives the required wrap to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count_reg <= '0;
    else if (inc) count_reg <= count_reg + 1'b1;
  end

  assign count = count_reg;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute controller for the program counter.
//   Fetches at the PC address, captures the word into the IR, issues it to
//   the execute unit and counts retired instructions.
//   States: IDLE -> FETCH -> DECODE -> EXEC -> FETCH | HALT, HALT -> FETCH.
//   Optional build macro SINGLE_STEP_EN: adds step_mode/step inputs and a
//   WAIT_STEP state entered after each non-halting retire when step_mode=1.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin/resume fetching (sampled in IDLE/HALT only)
//   imem_req            instruction read request (Moore, FETCH)
//   imem_ack/imem_rdata read completion and data
//   ir, ir_load         instruction register and its capture strobe
//   pc_inc, pc_load     PC increment / load strobes (mutually exclusive)
//   exec_start          one-cycle pulse in the first EXEC cycle
//   exec_done/jump/halt execute unit completion and its qualifiers
//   running, halted     status
//   retired             retired-instruction count
//   step_mode, step     (SINGLE_STEP_EN only) single-step control
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_load,
  output logic               pc_inc,
  output logic               pc_load,
  output logic               exec_start,
  input  logic               exec_done,
  input  logic               exec_jump,
  input  logic               exec_halt,
`ifdef SINGLE_STEP_EN
  input  logic               step_mode,
  input  logic               step,
`endif
  output logic               running,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  state_t             state_reg, state_next;
  logic               exec_first_reg;
  logic [INSTR_W-1:0] ir_reg;
  logic               retire_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      exec_first_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      // DECODE always leads to EXEC, so this marks the first EXEC cycle.
      exec_first_reg <= (state_reg == ST_DECODE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ir_reg <= '0;
    else if (ir_load) ir_reg <= imem_rdata;
  end

  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    exec_start = 1'b0;
    running    = 1'b0;
    halted     = 1'b0;
    retire_inc = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        running  = 1'b1;
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        running    = 1'b1;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        running    = 1'b1;
        exec_start = exec_first_reg;
        if (exec_done) begin
          retire_inc = 1'b1;
          // Halt takes priority: a halting instruction never loads the PC.
          if (exec_halt) begin
            state_next = ST_HALT;
          end else begin
            pc_load = exec_jump;
`ifdef SINGLE_STEP_EN
            state_next = step_mode ? ST_WAIT_STEP : ST_FETCH;
`else
            state_next = ST_FETCH;
`endif
          end
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (start) state_next = ST_FETCH;
      end
`ifdef SINGLE_STEP_EN
      ST_WAIT_STEP: begin
        running = 1'b1;
        if (step) state_next = ST_FETCH;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  fetch_sequencer_retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire_inc),
    .count (retired)
  );

  assign ir = ir_reg;

endmodule
